mips_main_control: RTL and testbench
====================================

Name: mips_main_control

Overview:
- Multicycle MIPS main control FSM, directly upstream of the ALU-control decoder; its o_aluOp feeds that decoder's 2-bit ALU-op input.
- Sequences each instruction through fetch/decode/execute/memory/writeback.
- Drives all datapath enables and muxes.
- Waits on a memory-ready handshake and keeps a retired-instruction counter.

Parameters:
COUNT_W, 32, width of retired-instruction counter o_instrCount

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous reset, active-high
i_op  in  6  opcode field instr[31:26] from instruction register
i_memReady  in  1  memory handshake: access completes in cycle it is high
o_iorD  out  1  address mux: 0=PC, 1=ALUOut
o_irWrite  out  1  instruction-register load
o_memWrite  out  1  memory write request
o_pcWrite  out  1  unconditional PC load
o_branch  out  1  conditional PC load (ANDed with zero in datapath)
o_pcSrc  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
o_aluSrcA  out  1  0=PC, 1=regA
o_aluSrcB  out  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
o_aluOp  out  2  00=add, 01=sub, 10=use funct field
o_regDst  out  1  0=rt, 1=rd
o_memToReg  out  1  0=ALUOut, 1=memory data reg
o_regWrite  out  1  register-file write
o_retire  out  1  one-cycle pulse on the final cycle of each instruction
o_illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode
o_state  out  4  current state encoding, for debug
o_instrCount  out  COUNT_W  retired-instruction count

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 are unreachable and go to FETCH on the next edge.
- Reset: on any edge with i_rst=1, the state becomes FETCH and o_instrCount becomes 0, including mid-instruction. There is no partial writeback after reset.
- All outputs are decoded combinationally from the state. Only the i_memReady gating is Mealy. Any output not listed for a state is 0.
- FETCH:
  - Outputs: iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSrc=00.
  - irWrite and pcWrite are asserted only when i_memReady=1.
  - Stays in FETCH while i_memReady=0; goes to DECODE when it is 1.
- DECODE:
  - Outputs: aluSrcA=0, aluSrcB=11, aluOp=00 (branch target into ALUOut).
  - Next state from i_op: 100011 lw -> MEMADR; 101011 sw -> MEMADR; 000000 R-type -> EXEC; 000100 beq -> BRANCH; 001000 addi -> ADDIEX; 000010 j -> JUMP.
  - Any other opcode -> FETCH, with o_illegal=1 for that cycle. No retire and no count increment.
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. Goes to MEMRD if i_op=lw, else MEMWR.
- MEMRD: iorD=1. Holds until i_memReady=1, then goes to MEMWB.
- MEMWB: regDst=0, memToReg=1, regWrite=1, retire. Goes to FETCH.
- MEMWR:
  - iorD=1, and memWrite=1 for every cycle spent in the state.
  - Holds until i_memReady=1.
  - Retire is asserted in the ready cycle, then the state goes to FETCH.
- EXEC: aluSrcA=1, aluSrcB=00, aluOp=10. Goes to ALUWB.
- ALUWB: regDst=1, memToReg=0, regWrite=1, retire. Goes to FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcSrc=01, branch=1, retire. Goes to FETCH.
- ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=00. Goes to ADDIWB.
- ADDIWB: regDst=0, memToReg=0, regWrite=1, retire. Goes to FETCH.
- JUMP: pcSrc=10, pcWrite=1, retire. Goes to FETCH.
- Latency with zero wait states (i_memReady=1):
  - lw 5 cycles; sw 4; R-type 4; addi 4; beq 3; j 3.
  - Each cycle with i_memReady=0 in FETCH, MEMRD or MEMWR adds one cycle.
- o_instrCount increments by 1 on each edge where o_retire=1. It wraps modulo 2^COUNT_W with no saturation.
- i_op is sampled only in DECODE and MEMADR. The IR is stable then because irWrite is low.

Test Plan:
- Reset then lw (i_op=100011), i_memReady=1 -> states 0,1,2,3,4,0; regWrite and memToReg high in MEMWB only; o_retire pulses once; count=1.
- R-type (000000) -> states 0,1,6,7; o_aluOp=10 in EXEC only; regDst=1 in ALUWB; o_aluOp=00 in FETCH and DECODE.
- sw with i_memReady low for 3 cycles in MEMWR -> memWrite high for 4 consecutive cycles; retire on the 4th; sw total 7 cycles.
- beq then j -> BRANCH drives aluOp=01, pcSrc=01, branch=1; JUMP drives pcSrc=10, pcWrite=1; count +2.
- Opcode 111111 in DECODE -> o_illegal pulses, state returns to 0, count unchanged. FETCH with i_memReady=0 -> irWrite=pcWrite=0 and state stays at 0.
- i_rst asserted in MEMRD -> next state 0, count=0, no regWrite. COUNT_W=4 with 17 retires -> count=1.

Source files
------------

// File: rtl/mips_main_control.sv
// Multicycle MIPS main control: sequences each instruction through
// fetch/decode/execute/memory/writeback, drives the datapath enables and
// muxes, waits on the memory-ready handshake and counts retired instructions.
module mips_main_control #(
    parameter int COUNT_W = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [5:0]         i_op,
    input  logic               i_memReady,
    output logic               o_iorD,
    output logic               o_irWrite,
    output logic               o_memWrite,
    output logic               o_pcWrite,
    output logic               o_branch,
    output logic [1:0]         o_pcSrc,
    output logic               o_aluSrcA,
    output logic [1:0]         o_aluSrcB,
    output logic [1:0]         o_aluOp,
    output logic               o_regDst,
    output logic               o_memToReg,
    output logic               o_regWrite,
    output logic               o_retire,
    output logic               o_illegal,
    output logic [3:0]         o_state,
    output logic [COUNT_W-1:0] o_instrCount
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RT   = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;

    // Output decode and next-state selection; only i_memReady gating is Mealy.
    always_comb begin
        state_d    = FETCH;
        o_iorD     = 1'b0;
        o_irWrite  = 1'b0;
        o_memWrite = 1'b0;
        o_pcWrite  = 1'b0;
        o_branch   = 1'b0;
        o_pcSrc    = 2'b00;
        o_aluSrcA  = 1'b0;
        o_aluSrcB  = 2'b00;
        o_aluOp    = 2'b00;
        o_regDst   = 1'b0;
        o_memToReg = 1'b0;
        o_regWrite = 1'b0;
        o_retire   = 1'b0;
        o_illegal  = 1'b0;
        case (state_q)
            FETCH: begin
                o_aluSrcB = 2'b01;
                o_irWrite = i_memReady;
                o_pcWrite = i_memReady;
                state_d   = i_memReady ? DECODE : FETCH;
            end
            DECODE: begin
                // Precompute the branch target into ALUOut.
                o_aluSrcB = 2'b11;
                case (i_op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RT:        state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d   = FETCH;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                o_aluSrcA = 1'b1;
                o_aluSrcB = 2'b10;
                state_d   = (i_op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                o_iorD  = 1'b1;
                state_d = i_memReady ? MEMWB : MEMRD;
            end
            MEMWB: begin
                o_memToReg = 1'b1;
                o_regWrite = 1'b1;
                o_retire   = 1'b1;
            end
            MEMWR: begin
                o_iorD     = 1'b1;
                o_memWrite = 1'b1;
                o_retire   = i_memReady;
                state_d    = i_memReady ? FETCH : MEMWR;
            end
            EXEC: begin
                o_aluSrcA = 1'b1;
                o_aluOp   = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                o_regDst   = 1'b1;
                o_regWrite = 1'b1;
                o_retire   = 1'b1;
            end
            BRANCH: begin
                o_aluSrcA = 1'b1;
                o_aluOp   = 2'b01;
                o_pcSrc   = 2'b01;
                o_branch  = 1'b1;
                o_retire  = 1'b1;
            end
            ADDIEX: begin
                o_aluSrcA = 1'b1;
                o_aluSrcB = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                o_regWrite = 1'b1;
                o_retire   = 1'b1;
            end
            JUMP: begin
                o_pcSrc   = 2'b10;
                o_pcWrite = 1'b1;
                o_retire  = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Retired-instruction counter wraps freely.
    always_comb begin
        count_d = count_q;
        if (o_retire) count_d = count_q + COUNT_W'(1);
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign o_state      = state_q;
    assign o_instrCount = count_q;

endmodule

// File: tb/tb_mips_main_control.sv
// Scoreboard bench for mips_main_control: the stimulus process pushes the
// hand-derived expected outputs for every cycle, a negedge monitor pops and
// compares. A second instance with COUNT_W=4 checks counter wrap.
module tb_mips_main_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic       rdy;

    always #5 clk = ~clk;

    logic        iorD, irWrite, memWrite, pcWrite, branch, aluSrcA;
    logic [1:0]  pcSrc, aluSrcB, aluOp;
    logic        regDst, memToReg, regWrite, retire, illegal;
    logic [3:0]  state;
    logic [31:0] cnt;

    logic        s_iorD, s_irWrite, s_memWrite, s_pcWrite, s_branch, s_aluSrcA;
    logic [1:0]  s_pcSrc, s_aluSrcB, s_aluOp;
    logic        s_regDst, s_memToReg, s_regWrite, s_retire, s_illegal;
    logic [3:0]  s_state;
    logic [3:0]  s_cnt;

    mips_main_control #(.COUNT_W(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_op(op), .i_memReady(rdy),
        .o_iorD(iorD), .o_irWrite(irWrite), .o_memWrite(memWrite),
        .o_pcWrite(pcWrite), .o_branch(branch), .o_pcSrc(pcSrc),
        .o_aluSrcA(aluSrcA), .o_aluSrcB(aluSrcB), .o_aluOp(aluOp),
        .o_regDst(regDst), .o_memToReg(memToReg), .o_regWrite(regWrite),
        .o_retire(retire), .o_illegal(illegal), .o_state(state),
        .o_instrCount(cnt)
    );

    mips_main_control #(.COUNT_W(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_op(op), .i_memReady(rdy),
        .o_iorD(s_iorD), .o_irWrite(s_irWrite), .o_memWrite(s_memWrite),
        .o_pcWrite(s_pcWrite), .o_branch(s_branch), .o_pcSrc(s_pcSrc),
        .o_aluSrcA(s_aluSrcA), .o_aluSrcB(s_aluSrcB), .o_aluOp(s_aluOp),
        .o_regDst(s_regDst), .o_memToReg(s_memToReg), .o_regWrite(s_regWrite),
        .o_retire(s_retire), .o_illegal(s_illegal), .o_state(s_state),
        .o_instrCount(s_cnt)
    );

    // Control vector packing:
    // {iorD, irWrite, memWrite, pcWrite, branch, pcSrc[1:0], aluSrcA,
    //  aluSrcB[1:0], aluOp[1:0], regDst, memToReg, regWrite, retire, illegal}
    logic [16:0] obs;
    assign obs = {iorD, irWrite, memWrite, pcWrite, branch, pcSrc, aluSrcA,
                  aluSrcB, aluOp, regDst, memToReg, regWrite, retire, illegal};

    localparam logic [16:0] C_FETCH_R  = {1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] C_FETCH_W  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] C_DECODE   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] C_DEC_ILL  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1};
    localparam logic [16:0] C_MEMADR   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] C_MEMRD    = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] C_MEMWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b1,1'b1,1'b1,1'b0};
    localparam logic [16:0] C_MEMWR_W  = {1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] C_MEMWR_R  = {1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0};
    localparam logic [16:0] C_EXEC     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] C_ALUWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b0,1'b1,1'b1,1'b0};
    localparam logic [16:0] C_BRANCH   = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b1,2'b00,2'b01,1'b0,1'b0,1'b0,1'b1,1'b0};
    localparam logic [16:0] C_ADDIEX   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] C_ADDIWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b1,1'b1,1'b0};
    localparam logic [16:0] C_JUMP     = {1'b0,1'b0,1'b0,1'b1,1'b0,2'b10,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0};

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] ctrl;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_cnt  = 0;

    // One cycle of stimulus: drive inputs, queue the expectation, advance.
    task automatic step(input logic r, input logic [5:0] o, input logic m,
                        input logic [3:0] est, input logic [16:0] ectrl);
        exp_t e;
        rst = r; op = o; rdy = m;
        e.st = est; e.ctrl = ectrl; e.cnt = exp_cnt;
        sb.push_back(e);
        if (r) exp_cnt = 0;
        else if (ectrl[1]) exp_cnt = exp_cnt + 1;
        @(posedge clk); #1;
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        logic [3:0] e4;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            e4 = e.cnt[3:0];
            n_checks++;
            if (state !== e.st) begin
                n_fail++;
                $display("FAIL state: got %0d expected %0d (t=%0t)", state, e.st, $time);
            end
            n_checks++;
            if (obs !== e.ctrl) begin
                n_fail++;
                $display("FAIL ctrl in state %0d: got %b expected %b (t=%0t)", e.st, obs, e.ctrl, $time);
            end
            n_checks++;
            if (cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL count: got %0d expected %0d (t=%0t)", cnt, e.cnt, $time);
            end
            n_checks++;
            if (s_cnt !== e4) begin
                n_fail++;
                $display("FAIL count4: got %0d expected %0d (t=%0t)", s_cnt, e4, $time);
            end
        end
    end

    initial begin
        rst = 1'b1; op = RT; rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // lw, zero wait: 0,1,2,3,4
        step(0, LW, 1, 4'd0, C_FETCH_R);
        step(0, LW, 1, 4'd1, C_DECODE);
        step(0, LW, 1, 4'd2, C_MEMADR);
        step(0, LW, 1, 4'd3, C_MEMRD);
        step(0, LW, 1, 4'd4, C_MEMWB);
        // R-type: 0,1,6,7
        step(0, RT, 1, 4'd0, C_FETCH_R);
        step(0, RT, 1, 4'd1, C_DECODE);
        step(0, RT, 1, 4'd6, C_EXEC);
        step(0, RT, 1, 4'd7, C_ALUWB);
        // sw with 3 wait cycles in MEMWR: 7 cycles total
        step(0, SW, 1, 4'd0, C_FETCH_R);
        step(0, SW, 1, 4'd1, C_DECODE);
        step(0, SW, 1, 4'd2, C_MEMADR);
        step(0, SW, 0, 4'd5, C_MEMWR_W);
        step(0, SW, 0, 4'd5, C_MEMWR_W);
        step(0, SW, 0, 4'd5, C_MEMWR_W);
        step(0, SW, 1, 4'd5, C_MEMWR_R);
        // beq then j
        step(0, BEQ, 1, 4'd0, C_FETCH_R);
        step(0, BEQ, 1, 4'd1, C_DECODE);
        step(0, BEQ, 1, 4'd8, C_BRANCH);
        step(0, JMP, 1, 4'd0, C_FETCH_R);
        step(0, JMP, 1, 4'd1, C_DECODE);
        step(0, JMP, 1, 4'd11, C_JUMP);
        // FETCH stall, then illegal opcode
        step(0, BAD, 0, 4'd0, C_FETCH_W);
        step(0, BAD, 0, 4'd0, C_FETCH_W);
        step(0, BAD, 1, 4'd0, C_FETCH_R);
        step(0, BAD, 1, 4'd1, C_DEC_ILL);
        // 12 addi instructions bring the total to 17 retires (4-bit count = 1)
        for (int i = 0; i < 12; i++) begin
            step(0, ADDI, 1, 4'd0, C_FETCH_R);
            step(0, ADDI, 1, 4'd1, C_DECODE);
            step(0, ADDI, 1, 4'd9, C_ADDIEX);
            step(0, ADDI, 1, 4'd10, C_ADDIWB);
        end
        // lw interrupted by reset in MEMRD: no writeback, count cleared
        step(0, LW, 1, 4'd0, C_FETCH_R);
        step(0, LW, 1, 4'd1, C_DECODE);
        step(0, LW, 1, 4'd2, C_MEMADR);
        step(0, LW, 0, 4'd3, C_MEMRD);
        step(1, LW, 1, 4'd3, C_MEMRD);
        step(0, LW, 0, 4'd0, C_FETCH_W);
        step(0, LW, 1, 4'd0, C_FETCH_R);
        step(0, LW, 1, 4'd1, C_DECODE);
        // let the monitor drain, bounded
        for (int k = 0; k < 4 && sb.size() > 0; k++) @(posedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
